// File: rtl/sd_card_detect.sv
// SD socket CD/WP conditioning: sync, polarity, CD debounce, insert/remove events.
// Define SDHCI_WP_DEBOUNCE_EN to also debounce WP on the shared prescaler tick.
module sd_card_detect #(
   parameter int unsigned PrescaleCycles = 1000,
   parameter int unsigned DebounceTicks  = 16,
   parameter bit          CdActiveLow    = 1'b1
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic cd_pin_i,
   input  logic wp_pin_i,
   input  logic cd_test_sel_i,
   input  logic cd_test_level_i,
   output logic card_inserted_o,
   output logic card_state_stable_o,
   output logic card_detect_pin_level_o,
   output logic write_protect_pin_level_o,
   output logic card_insertion_o,
   output logic card_removal_o
);

   localparam int unsigned PW =
      (PrescaleCycles > 1) ? $clog2(PrescaleCycles) : 1;
   localparam logic [PW-1:0] PreMax = PW'(PrescaleCycles - 1);
   localparam logic [7:0]    DebMax = 8'(DebounceTicks);

   typedef enum logic [1:0] {
      ST_UNKNOWN,
      ST_ABSENT,
      ST_PRESENT
   } state_e;

   logic          cd_s1_q, cd_s2_q;
   logic          wp_s1_q, wp_s2_q;
   logic          cd_lvl, cd_lvl_q;
   logic [PW-1:0] pre_q, pre_d;
   logic          tick;
   logic [7:0]    deb_q, deb_d;
   logic          settled;
   state_e        state_q, state_d;
   logic          ins_d, rem_d;
   logic          inserted_q, stable_q;
   logic          ins_q, rem_q, wp_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cd_s1_q <= 1'b0;
         cd_s2_q <= 1'b0;
         wp_s1_q <= 1'b0;
         wp_s2_q <= 1'b0;
      end else begin
         cd_s1_q <= cd_pin_i;
         cd_s2_q <= cd_s1_q;
         wp_s1_q <= wp_pin_i;
         wp_s2_q <= wp_s1_q;
      end
   end

   // Test level bypasses the synchroniser on purpose: it comes from a register.
   assign cd_lvl = cd_test_sel_i ? cd_test_level_i
                                 : (cd_s2_q ^ CdActiveLow);

   assign tick    = (pre_q == PreMax);
   assign pre_d   = tick ? '0 : pre_q + PW'(1);
   assign settled = (deb_q == DebMax);

   always_comb begin
      deb_d = deb_q;
      if (cd_lvl != cd_lvl_q) begin
         deb_d = '0;
      end else if (tick && !settled) begin
         deb_d = deb_q + 8'd1;
      end
   end

   // cd_lvl_q is the level the debounce counter has been timing.
   always_comb begin
      state_d = state_q;
      ins_d   = 1'b0;
      rem_d   = 1'b0;
      if (settled) begin
         unique case (state_q)
            ST_UNKNOWN: begin
               state_d = cd_lvl_q ? ST_PRESENT : ST_ABSENT;
               ins_d   = cd_lvl_q;
            end
            ST_ABSENT: begin
               if (cd_lvl_q) begin
                  state_d = ST_PRESENT;
                  ins_d   = 1'b1;
               end
            end
            ST_PRESENT: begin
               if (!cd_lvl_q) begin
                  state_d = ST_ABSENT;
                  rem_d   = 1'b1;
               end
            end
            default: state_d = ST_UNKNOWN;
         endcase
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cd_lvl_q   <= 1'b0;
         pre_q      <= '0;
         deb_q      <= '0;
         state_q    <= ST_UNKNOWN;
         inserted_q <= 1'b0;
         stable_q   <= 1'b0;
         ins_q      <= 1'b0;
         rem_q      <= 1'b0;
      end else begin
         cd_lvl_q   <= cd_lvl;
         pre_q      <= pre_d;
         deb_q      <= deb_d;
         state_q    <= state_d;
         inserted_q <= (state_d == ST_PRESENT);
         stable_q   <= settled && (state_d != ST_UNKNOWN);
         ins_q      <= ins_d;
         rem_q      <= rem_d;
      end
   end

`ifdef SDHCI_WP_DEBOUNCE_EN
   logic       wp_prev_q;
   logic [7:0] wp_cnt_q, wp_cnt_d;

   always_comb begin
      wp_cnt_d = wp_cnt_q;
      if (wp_s2_q != wp_prev_q) begin
         wp_cnt_d = '0;
      end else if (tick && (wp_cnt_q != DebMax)) begin
         wp_cnt_d = wp_cnt_q + 8'd1;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wp_prev_q <= 1'b0;
         wp_cnt_q  <= '0;
         wp_q      <= 1'b1;
      end else begin
         wp_prev_q <= wp_s2_q;
         wp_cnt_q  <= wp_cnt_d;
         if (wp_cnt_q == DebMax) begin
            wp_q <= wp_prev_q;
         end
      end
   end
`else
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wp_q <= 1'b0;
      end else begin
         wp_q <= wp_s2_q;
      end
   end
`endif

   assign card_inserted_o           = inserted_q;
   assign card_state_stable_o       = stable_q;
   assign card_detect_pin_level_o   = cd_lvl_q;
   assign write_protect_pin_level_o = wp_q;
   assign card_insertion_o          = ins_q;
   assign card_removal_o            = rem_q;

endmodule

// File: tb/tb_sd_card_detect.sv
// Bench for sd_card_detect: per-cycle reference model plus directed literals.
// The model tracks pin histories and counts ticks arithmetically.
module tb_sd_card_detect;

   localparam int P    = 4;
   localparam int D    = 3;
   localparam bit CDAL = 1'b1;
   localparam int MAXC = 4096;
`ifdef SDHCI_WP_DEBOUNCE_EN
   localparam bit WP_RST = 1'b1;
`else
   localparam bit WP_RST = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst_ni = 1'b0;
   logic cd_pin_i = 1'b0;
   logic wp_pin_i = 1'b1;
   logic cd_test_sel_i = 1'b0;
   logic cd_test_level_i = 1'b0;
   logic card_inserted_o, card_state_stable_o;
   logic card_detect_pin_level_o, write_protect_pin_level_o;
   logic card_insertion_o, card_removal_o;

   always #5 clk = ~clk;

   sd_card_detect #(
      .PrescaleCycles(P),
      .DebounceTicks (D),
      .CdActiveLow   (CDAL)
   ) dut (
      .clk_i                    (clk),
      .rst_ni                   (rst_ni),
      .cd_pin_i                 (cd_pin_i),
      .wp_pin_i                 (wp_pin_i),
      .cd_test_sel_i            (cd_test_sel_i),
      .cd_test_level_i          (cd_test_level_i),
      .card_inserted_o          (card_inserted_o),
      .card_state_stable_o      (card_state_stable_o),
      .card_detect_pin_level_o  (card_detect_pin_level_o),
      .write_protect_pin_level_o(write_protect_pin_level_o),
      .card_insertion_o         (card_insertion_o),
      .card_removal_o           (card_removal_o)
   );

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   bit pin_h[MAXC];
   bit sel_h[MAXC];
   bit tl_h[MAXC];
   bit wp_h[MAXC];
   int lastchg = -1;
   int acc = -1;
   int wlast = -1;
   bit wout = WP_RST;

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at cycle %0d: got %0d, expected %0d",
                  name, cyc, act, exp);
      end
   endtask

   // Tick cycles in the interval range (l, c].
   function automatic int ticks(input int l, input int c);
      return (c + 1) / P - (l + 1) / P;
   endfunction

   function automatic bit lvl_at(input int k);
      bit s;
      s = (k >= 2) ? pin_h[k-2] : 1'b0;
      return sel_h[k] ? tl_h[k] : (s ^ CDAL);
   endfunction

   function automatic bit wpl_at(input int k);
      return (k >= 2) ? wp_h[k-2] : 1'b0;
   endfunction

   // acc: accepted card level, -1 until the first settle after reset.
   always @(posedge clk) begin : model
      int k;
      bit lv, lvq, settled, ins, rem, wexp;
      #1;
      if (!rst_ni) begin
         cyc = 0;
         lastchg = -1;
         acc = -1;
         wlast = -1;
         wout = WP_RST;
      end else if (cyc < MAXC) begin
         k = cyc;
         pin_h[k] = cd_pin_i;
         sel_h[k] = cd_test_sel_i;
         tl_h[k]  = cd_test_level_i;
         wp_h[k]  = wp_pin_i;
         lv  = lvl_at(k);
         lvq = (k >= 1) ? lvl_at(k - 1) : 1'b0;
         settled = ticks(lastchg, k - 1) >= D;
         ins = 1'b0;
         rem = 1'b0;
         if (settled && acc != int'(lvq)) begin
            ins = lvq;
            rem = !lvq && acc == 1;
            acc = int'(lvq);
         end
         if (lv != lvq) lastchg = k;
`ifdef SDHCI_WP_DEBOUNCE_EN
         if (ticks(wlast, k - 1) >= D)
            wout = (k >= 1) ? wpl_at(k - 1) : 1'b0;
         if (wpl_at(k) != ((k >= 1) ? wpl_at(k - 1) : 1'b0))
            wlast = k;
         wexp = wout;
`else
         wexp = wpl_at(k);
`endif
         cyc = k + 1;
         chk("card_inserted", card_inserted_o, acc == 1);
         chk("card_state_stable", card_state_stable_o,
             settled && acc != -1);
         chk("card_insertion", card_insertion_o, ins);
         chk("card_removal", card_removal_o, rem);
         chk("cd_pin_level", card_detect_pin_level_o, lv);
         chk("wp_pin_level", write_protect_pin_level_o, wexp);
      end
   end

   int w_ni, w_nr, w_fi, w_fr, w_fs, w_slo, w_ilo, w_wlo;

   task automatic watch(input int n);
      w_ni = 0; w_nr = 0; w_fi = -1; w_fr = -1; w_fs = -1;
      w_slo = 0; w_ilo = 0; w_wlo = 0;
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #3;
         if (card_insertion_o) begin
            w_ni++;
            if (w_fi < 0) w_fi = cyc;
         end
         if (card_removal_o) begin
            w_nr++;
            if (w_fr < 0) w_fr = cyc;
         end
         if (card_state_stable_o && w_fs < 0) w_fs = cyc;
         if (!card_state_stable_o) w_slo++;
         if (!card_inserted_o) w_ilo++;
         if (!write_protect_pin_level_o) w_wlo++;
      end
   endtask

   task automatic check_reset_vals();
      chk("rst_inserted", card_inserted_o, 0);
      chk("rst_stable", card_state_stable_o, 0);
      chk("rst_insertion", card_insertion_o, 0);
      chk("rst_removal", card_removal_o, 0);
      chk("rst_cd_level", card_detect_pin_level_o, 0);
      chk("rst_wp_level", write_protect_pin_level_o, WP_RST);
   endtask

   initial begin
      int wsum;
      repeat (3) @(posedge clk);
      #3;
      check_reset_vals();
      rst_ni = 1'b1;

      // power-up with card
      watch(40);
      chk("pwr_ins_cycle", w_fi, 13);
      chk("pwr_ins_count", w_ni, 1);
      chk("pwr_rem_count", w_nr, 0);
      chk("pwr_inserted", card_inserted_o, 1);
      chk("pwr_stable", card_state_stable_o, 1);

      // 6-cycle glitch
      cd_pin_i = 1'b1;
      watch(6);
      cd_pin_i = 1'b0;
      watch(30);
      chk("glitch_rem_count", w_nr, 0);
      chk("glitch_inserted_low", w_ilo, 0);
      chk("glitch_stable_dip", w_slo > 0, 1);
      chk("glitch_stable_end", card_state_stable_o, 1);

      // removal
      cd_pin_i = 1'b1;
      watch(30);
      chk("rem_cycle", w_fr, 89);
      chk("rem_count", w_nr, 1);
      chk("rem_ins_count", w_ni, 0);
      chk("rem_inserted", card_inserted_o, 0);

      // test mode insertion then back to the pin
      cd_test_sel_i = 1'b1;
      cd_test_level_i = 1'b1;
      watch(30);
      chk("test_ins_cycle", w_fi, 117);
      chk("test_ins_count", w_ni, 1);
      chk("test_pin_level", card_detect_pin_level_o, 1);
      cd_test_sel_i = 1'b0;
      cd_test_level_i = 1'b0;
      watch(30);
      chk("test_off_rem_cycle", w_fr, 149);
      chk("test_off_rem_count", w_nr, 1);

      // reset mid-debounce
      cd_pin_i = 1'b0;
      watch(5);
      rst_ni = 1'b0;
      #1;
      check_reset_vals();
      repeat (2) @(posedge clk);
      #3;
      rst_ni = 1'b1;
      watch(20);
      chk("rstmid_ins_cycle", w_fi, 13);
      chk("rstmid_ins_count", w_ni, 1);

      // power-up without card
      rst_ni = 1'b0;
      cd_pin_i = 1'b1;
      repeat (2) @(posedge clk);
      #3;
      rst_ni = 1'b1;
      watch(20);
      chk("nocard_stable_cycle", w_fs, 13);
      chk("nocard_ins_count", w_ni, 0);
      chk("nocard_rem_count", w_nr, 0);
      chk("nocard_inserted_low", w_ilo, 20);

      // 5-cycle WP pulse
      wp_pin_i = 1'b0;
      watch(5);
      wsum = w_wlo;
      wp_pin_i = 1'b1;
      watch(20);
      wsum += w_wlo;
`ifdef SDHCI_WP_DEBOUNCE_EN
      chk("wp_pulse_low_cycles", wsum, 0);
`else
      chk("wp_pulse_low_cycles", wsum, 5);
`endif

      // randomized stretch
      for (int n = 0; n < 2000;) begin
         int hold;
         hold = $urandom_range(1, 40);
         cd_pin_i = 1'($urandom);
         wp_pin_i = 1'($urandom);
         cd_test_level_i = 1'($urandom);
         if ($urandom_range(0, 7) == 0) cd_test_sel_i = ~cd_test_sel_i;
         if ($urandom_range(0, 49) == 0) begin
            rst_ni = 1'b0;
            repeat (2) @(posedge clk);
            #3;
            rst_ni = 1'b1;
         end
         repeat (hold) @(posedge clk);
         #3;
         n += hold;
      end

      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end

endmodule
